// File: rtl/jtframe_dump_pkg.sv
// Shared definitions for the frame-triggered trace dump controller:
// capture state encoding and the "until buffer full" frame length.
package jtframe_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } dump_state_e;

    // frame_len value meaning "keep capturing until the buffer is full"
    localparam logic [7:0] LEN_UNTIL_FULL = 8'd0;

endpackage

// File: rtl/jtframe_frame_cnt.sv
// Vertical-sync falling-edge detector and 32-bit frame counter.
// Both are held off while a ROM download is in progress.
module jtframe_frame_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs,
    input  logic        downloading,
    output logic        frame_evt,
    output logic [31:0] frame_cnt
);

    logic        vs_q;
    logic        primed;
    logic [31:0] cnt;

    // primed masks the first cycle after reset so a vs already low at
    // release is never taken for a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b1;
            primed <= 1'b0;
        end else begin
            vs_q   <= vs;
            primed <= 1'b1;
        end
    end

    assign frame_evt = primed & vs_q & ~vs & ~downloading;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 32'd0;
        end else if (downloading) begin
            cnt <= 32'd0;
        end else if (frame_evt) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign frame_cnt = cnt;

endmodule

// File: rtl/frame_dump_ctl.sv
// Frame-triggered trace capture: armed on request, starts on a chosen frame
// number and streams qualified samples into a trace buffer write port.
module frame_dump_ctl
    import jtframe_dump_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    input  logic          downloading,
    input  logic [31:0]   start_frame,
    input  logic [7:0]    frame_len,
    input  logic          arm,
    input  logic          sample_en,
    input  logic [DW-1:0] din,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [31:0]   frame_cnt,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   wr_count,
    output dump_state_e   state
);

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    dump_state_e state_q, state_d;
    logic        frame_evt;
    logic        dl_q, dl_rise;
    logic        full, start_hit, len_hit, arm_ok, take;
    logic [7:0]  frames_cap;

    jtframe_frame_cnt u_frame_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs          (vs),
        .downloading (downloading),
        .frame_evt   (frame_evt),
        .frame_cnt   (frame_cnt)
    );

    // sample_en is a valid-only qualifier with no backpressure: a sample is
    // either written on the next edge or dropped, never held over.
    assign dl_rise   = downloading & ~dl_q;
    assign full      = wr_count[AW];
    assign start_hit = frame_evt && (frame_cnt + 32'd1 == start_frame);
    assign len_hit   = frame_evt && (frame_len != LEN_UNTIL_FULL)
                       && (frames_cap + 8'd1 == frame_len);
    assign arm_ok    = arm && (state_q == ST_IDLE || state_q == ST_DONE);
    assign take      = (state_q == ST_CAPTURE) && !dl_rise && sample_en
                       && !full && !len_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arm) state_d = ST_ARMED;
            ST_ARMED: begin
                if (dl_rise)        state_d = ST_IDLE;
                else if (start_hit) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (dl_rise)               state_d = ST_IDLE;
                else if (full || len_hit)  state_d = ST_DONE;
            end
            ST_DONE:    if (arm) state_d = ST_ARMED;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_ARMED, ST_CAPTURE: busy = 1'b1;
            ST_DONE:              done = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            wr_count   <= '0;
            overflow   <= 1'b0;
            frames_cap <= 8'd0;
        end else begin
            dl_q   <= downloading;
            mem_we <= take;
            if (take) begin
                mem_addr <= wr_count[AW-1:0];
                mem_din  <= din;
                wr_count <= wr_count + ONE;
            end
            if (arm_ok) begin
                wr_count <= '0;
                overflow <= 1'b0;
            end
            if (state_q == ST_ARMED && start_hit) frames_cap <= 8'd0;
            // an abort keeps wr_count and flags as they were
            if (state_q == ST_CAPTURE && !dl_rise) begin
                if (full)      overflow   <= 1'b1;
                if (frame_evt) frames_cap <= frames_cap + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_dump_ctl.sv
// Scoreboard bench for frame_dump_ctl: two instances (AW=10 and AW=4) share
// randomized stimulus and are checked against a frame-level reference model.
module tb_frame_dump_ctl;
    import jtframe_dump_pkg::*;

    localparam int AW0 = 10;
    localparam int AW1 = 4;
    localparam int DW  = 16;
    localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_FIN = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vs, downloading, arm, sample_en;
    logic [31:0]   start_frame;
    logic [7:0]    frame_len;
    logic [DW-1:0] din;

    logic           mem_we0, mem_we1;
    logic [AW0-1:0] mem_addr0;
    logic [AW1-1:0] mem_addr1;
    logic [DW-1:0]  mem_din0, mem_din1;
    logic [31:0]    frame_cnt0, frame_cnt1;
    logic           busy0, busy1, done0, done1, ovf0, ovf1;
    logic [AW0:0]   wr_count0;
    logic [AW1:0]   wr_count1;
    dump_state_e    state0, state1;

    frame_dump_ctl #(.AW(AW0), .DW(DW)) dut0 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .start_frame(start_frame), .frame_len(frame_len), .arm(arm),
        .sample_en(sample_en), .din(din), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_din(mem_din0), .frame_cnt(frame_cnt0), .busy(busy0), .done(done0),
        .overflow(ovf0), .wr_count(wr_count0), .state(state0)
    );

    frame_dump_ctl #(.AW(AW1), .DW(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .start_frame(start_frame), .frame_len(frame_len), .arm(arm),
        .sample_en(sample_en), .din(din), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_din(mem_din1), .frame_cnt(frame_cnt1), .busy(busy1), .done(done1),
        .overflow(ovf1), .wr_count(wr_count1), .state(state1)
    );

    // clock / reset block
    initial forever #5 clk = ~clk;

    // scoreboard state
    logic [AW0+DW-1:0] exp_q0[$];
    logic [AW1+DW-1:0] exp_q1[$];
    logic [AW0+DW-1:0] e0;
    logic [AW1+DW-1:0] e1;
    int n_tests = 0;
    int n_fail  = 0;
    int n_wr1   = 0;
    logic [31:0] preload_val;

    // reference model: frame number, and per-instance capture progress
    logic [31:0] m_frame;
    logic        m_vs_prev, m_primed, m_dl_prev;
    int          m_mode[2];
    int          m_count[2];
    int          m_frames[2];
    logic        m_over[2];
    int          cap[2] = '{1 << AW0, 1 << AW1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_frame   = 32'd0;
        m_vs_prev = 1'b1;
        m_primed  = 1'b0;
        m_dl_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_count[i] = 0; m_frames[i] = 0; m_over[i] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Advance the model by one clock using the inputs just driven.
    task automatic model_step();
        logic new_frame, dl_up, is_full, last_frame;
        new_frame = m_primed && m_vs_prev && !vs && !downloading;
        dl_up     = downloading && !m_dl_prev;
        for (int i = 0; i < 2; i++) begin
            if (m_mode[i] == M_IDLE || m_mode[i] == M_FIN) begin
                if (arm) begin
                    m_mode[i] = M_WAIT; m_count[i] = 0; m_over[i] = 1'b0;
                end
            end else if (dl_up) begin
                m_mode[i] = M_IDLE;
            end else if (m_mode[i] == M_WAIT) begin
                if (new_frame && (m_frame + 32'd1) == start_frame) begin
                    m_mode[i] = M_CAP; m_frames[i] = 0;
                end
            end else begin
                is_full    = (m_count[i] == cap[i]);
                last_frame = new_frame && frame_len != 8'd0 && (m_frames[i] + 1 == int'(frame_len));
                if (is_full) m_over[i] = 1'b1;
                if (sample_en && !is_full && !last_frame) begin
                    if (i == 0) exp_q0.push_back({AW0'(m_count[i]), din});
                    else        exp_q1.push_back({AW1'(m_count[i]), din});
                    m_count[i]++;
                end
                if (new_frame) m_frames[i]++;
                if (is_full || last_frame) m_mode[i] = M_FIN;
            end
        end
        if (downloading)    m_frame = 32'd0;
        else if (new_frame) m_frame = m_frame + 32'd1;
        m_vs_prev = vs;
        m_primed  = 1'b1;
        m_dl_prev = downloading;
    endtask

    // monitor: pop/compare writes and compare status every cycle
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (mem_we0) begin
                if (exp_q0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL write0: unexpected write addr 0x%0h data 0x%0h", mem_addr0, mem_din0);
                end else begin
                    e0 = exp_q0.pop_front();
                    chk("write0", {mem_addr0, mem_din0}, e0);
                end
            end
            if (mem_we1) begin
                n_wr1++;
                if (exp_q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL write1: unexpected write addr 0x%0h data 0x%0h", mem_addr1, mem_din1);
                end else begin
                    e1 = exp_q1.pop_front();
                    chk("write1", {mem_addr1, mem_din1}, e1);
                end
            end
            chk("frame_cnt0", frame_cnt0, m_frame);
            chk("frame_cnt1", frame_cnt1, m_frame);
            chk("wr_count0", wr_count0, 64'(m_count[0]));
            chk("wr_count1", wr_count1, 64'(m_count[1]));
            chk("busy0", busy0, m_mode[0] == M_WAIT || m_mode[0] == M_CAP);
            chk("busy1", busy1, m_mode[1] == M_WAIT || m_mode[1] == M_CAP);
            chk("done0", done0, m_mode[0] == M_FIN);
            chk("done1", done1, m_mode[1] == M_FIN);
            chk("overflow0", ovf0, m_over[0]);
            chk("overflow1", ovf1, m_over[1]);
        end
    end

    // driver tasks
    task automatic cycle(input logic v, input logic dl, input logic a, input logic se);
        @(negedge clk);
        vs = v; downloading = dl; arm = a; sample_en = se;
        din = DW'($urandom);
        model_step();
    endtask

    // se_mode: 0 none, 1 every 4th clk, 2 constant, 3 random
    task automatic run_frames(input int n, input int period, input int se_mode, input int arm_pct);
        logic v, se, a;
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < period; c++) begin
                v = !(c >= 2 && c < 5);
                case (se_mode)
                    0:       se = 1'b0;
                    1:       se = (c % 4 == 0);
                    2:       se = 1'b1;
                    default: se = ($urandom_range(0, 1) == 1);
                endcase
                a = ($urandom_range(0, 99) < arm_pct);
                cycle(v, 1'b0, a, se);
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_we0"}, mem_we0, 0);
        chk({tag, "_mem_we1"}, mem_we1, 0);
        chk({tag, "_mem_addr0"}, mem_addr0, 0);
        chk({tag, "_mem_din0"}, mem_din0, 0);
        chk({tag, "_frame_cnt0"}, frame_cnt0, 0);
        chk({tag, "_wr_count0"}, wr_count0, 0);
        chk({tag, "_wr_count1"}, wr_count1, 0);
        chk({tag, "_flags0"}, {busy0, done0, ovf0}, 0);
        chk({tag, "_flags1"}, {busy1, done1, ovf1}, 0);
    endtask

    task automatic preload(input logic [31:0] v);
        @(negedge clk);
        preload_val = v;
        force dut0.u_frame_cnt.cnt = preload_val;
        force dut1.u_frame_cnt.cnt = preload_val;
        #1;
        release dut0.u_frame_cnt.cnt;
        release dut1.u_frame_cnt.cnt;
        m_frame = v;
        vs = 1'b1; downloading = 1'b0; arm = 1'b0; sample_en = 1'b0;
        model_step();
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_pending0"}, exp_q0.size(), 0);
        chk({tag, "_pending1"}, exp_q1.size(), 0);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; vs = 1'b1; downloading = 1'b0; arm = 1'b0; sample_en = 1'b0;
        din = '0; start_frame = 32'd0; frame_len = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        release_reset();

        // capture from frame 3 for 2 frames, sample every 4th clk
        start_frame = 32'd3; frame_len = 8'd2;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        run_frames(3, 100, 1, 0);
        settle();
        chk("s1_state_capture", state0, ST_CAPTURE);
        chk("s1_frame_at_start", frame_cnt0, 32'd3);
        run_frames(2, 100, 1, 0);
        settle();
        chk("s1_done", done0, 1);
        chk("s1_frame_at_done", frame_cnt0, 32'd5);
        chk("s1_wr_count", wr_count0, 50);
        chk("s1_overflow", ovf0, 0);
        chk_drained("s1");

        // until-full capture with constant sample_en
        start_frame = m_frame + 32'd1; frame_len = 8'd0; n_wr1 = 0;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        run_frames(2, 100, 2, 0);
        settle();
        chk("s2_writes_aw4", n_wr1, 16);
        chk("s2_wr_count_aw4", wr_count1, 16);
        chk("s2_overflow_aw4", ovf1, 1);
        chk("s2_done_aw4", done1, 1);
        run_frames(9, 100, 2, 0);
        settle();
        chk("s2_wr_count_aw10", wr_count0, 1024);
        chk("s2_overflow_aw10", ovf0, 1);
        chk_drained("s2");

        // download abort after 7 writes
        start_frame = m_frame + 32'd1; frame_len = 8'd0;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        run_frames(1, 100, 0, 0);
        repeat (7) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        chk("s3_state_idle", state0, ST_IDLE);
        chk("s3_mem_we", mem_we0, 0);
        chk("s3_wr_count", wr_count0, 7);
        chk("s3_frame_cnt", frame_cnt0, 0);
        for (int c = 0; c < 20; c++) cycle(c % 10 >= 3, 1'b1, 1'b0, 1'b1);
        settle();
        chk("s3_frame_held", frame_cnt0, 0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // frame counter wrap with start_frame at the top value
        preload(32'hFFFF_FFFC);
        start_frame = 32'hFFFF_FFFF; frame_len = 8'd3;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        run_frames(3, 60, 3, 0);
        settle();
        chk("s4_state_capture", state0, ST_CAPTURE);
        chk("s4_frame_top", frame_cnt0, 32'hFFFF_FFFF);
        run_frames(1, 60, 3, 0);
        settle();
        chk("s4_frame_wrapped", frame_cnt0, 0);
        chk("s4_still_capture", state0, ST_CAPTURE);
        run_frames(2, 60, 3, 0);
        settle();
        chk("s4_done", done0, 1);

        // stray arm pulses while busy, then re-arm from DONE
        start_frame = m_frame + 32'd2; frame_len = 8'd2;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        run_frames(3, 50, 3, 5);
        run_frames(1, 50, 3, 0);
        settle();
        chk("s5_done", done0, 1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        chk("s5_rearm_state", state0, ST_ARMED);
        chk("s5_rearm_wr_count", wr_count0, 0);

        // reset mid-capture, vs held low through release
        start_frame = m_frame + 32'd1; frame_len = 8'd0;
        run_frames(1, 40, 2, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("s6_async");
        model_reset();
        vs = 1'b0; arm = 1'b0; sample_en = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("s6_frame_cnt", frame_cnt0, 0);
        chk("s6_state", state0, ST_IDLE);
        run_frames(2, 20, 3, 0);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            start_frame = m_frame + 32'($urandom_range(1, 2));
            frame_len   = 8'($urandom_range(0, 3));
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            run_frames($urandom_range(2, 4), $urandom_range(10, 40), 3, 2);
            if ($urandom_range(0, 2) == 0) begin
                repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1);
                cycle(1'b1, 1'b0, 1'b0, 1'b0);
            end
        end

        settle();
        chk_drained("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
